// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, with stall generation.
// Optional macro ARB_STARVE_GUARD_EN bounds consecutive data grants while a fetch waits.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_valid,
    input  logic [3:0]              dm_read_write,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_be,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    dm_valid,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready,
    output logic                    stall_if,
    output logic                    stall_mem
);

    typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

    state_t state;
    logic   dm_load;
    logic   dm_store;
    logic   dm_pend;
    logic   arb_open;
    logic   starve;
    logic   grant_data;
    logic   grant_fetch;

    assign dm_load   = (dm_read_write == 4'b0001);
    assign dm_store  = (dm_read_write == 4'b0010);
    assign dm_pend   = dm_load | dm_store;
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_pend & ~dm_valid;

    // While a valid pulse is out the requester still shows the old request, so
    // the cycle after completion is a turnaround in which nothing is granted.
    assign arb_open = (state == IDLE) && !dm_valid && !if_valid;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_WIDTH = $clog2(MAX_DATA_BURST + 1);
    logic [CNT_WIDTH-1:0] burst_cnt;

    assign starve = if_req && (burst_cnt == CNT_WIDTH'(MAX_DATA_BURST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (grant_fetch) begin
            burst_cnt <= '0;
        end else if (grant_data && if_req) begin
            burst_cnt <= burst_cnt + 1'b1;
        end else if (state == IDLE && !if_req) begin
            burst_cnt <= '0;
        end
    end
`else
    assign starve = 1'b0;
`endif

    // NOTE: combinational blocks assign every output first so no latch is inferred.
    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (arb_open) begin
            grant_fetch = if_req && (!dm_pend || starve);
            grant_data  = dm_pend && !grant_fetch;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            dm_rdata  <= '0;
            dm_valid  <= 1'b0;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
        end else begin
            dm_valid <= 1'b0;
            if_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state     <= DATA;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_store;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_be    <= dm_store ? dm_be : '1;
                    end else if (grant_fetch) begin
                        state     <= FETCH;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                    end
                end
                DATA: begin
                    if (mem_ready) begin
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                        dm_valid <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        if_rdata <= mem_rdata;
                        if_valid <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a latency-programmable memory responder,
// expected completions queued at stimulus time and checked on every valid pulse.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    typedef struct {
        bit          is_fetch;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic [3:0]    dm_read_write = 4'b0000;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [BW-1:0] dm_be = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          stall_if;
    logic          stall_mem;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   wait_lat = 0;
    int   wcnt = 0;
    exp_t sb[$];
    logic [31:0] last_dm = '0;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_DATA_BURST(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_read_write(dm_read_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Memory responder: ready after wait_lat low cycles of an outstanding request.
    always @(negedge clk) begin
        mem_rdata = memf(mem_addr);
        if (!mem_req) begin
            mem_ready = 1'b0;
            wcnt = 0;
        end else if (wcnt >= wait_lat) begin
            mem_ready = 1'b1;
        end else begin
            mem_ready = 1'b0;
            wcnt++;
        end
    end

    // Completion monitor: pops the scoreboard in order.
    always @(negedge clk) begin
        if (rst_n && (dm_valid || if_valid)) begin
            check("valid_onehot", {63'd0, dm_valid & if_valid}, 64'd0);
            check("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("grant_kind", {63'd0, if_valid}, {63'd0, e.is_fetch});
                if (e.is_fetch) check("if_rdata", {32'd0, if_rdata}, {32'd0, e.data});
                else            check("dm_rdata", {32'd0, dm_rdata}, {32'd0, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input bit fetch, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!(fetch ? if_valid : dm_valid) && n < 60) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_timeout"}, {63'd0, n < 60}, 64'd1);
    endtask

    task automatic wait_any(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!(if_valid || dm_valid) && n < 60) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_timeout"}, {63'd0, n < 60}, 64'd1);
    endtask

    task automatic push(input bit f, input logic [31:0] d);
        exp_t e;
        e.is_fetch = f;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_req"},  {63'd0, mem_req}, 64'd0);
        check({tag, "_mem_we"},   {63'd0, mem_we}, 64'd0);
        check({tag, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
        check({tag, "_mem_wdata"},{32'd0, mem_wdata}, 64'd0);
        check({tag, "_mem_be"},   {60'd0, mem_be}, 64'd0);
        check({tag, "_dm_rdata"}, {32'd0, dm_rdata}, 64'd0);
        check({tag, "_if_rdata"}, {32'd0, if_rdata}, 64'd0);
        check({tag, "_valids"},   {62'd0, dm_valid, if_valid}, 64'd0);
        check({tag, "_stalls"},   {62'd0, stall_if, stall_mem}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_dm;
        int t_if;

        // Reset state
        #2;
        check_idle_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single load, zero wait states
        wait_lat = 0;
        tick();
        dm_read_write = 4'b0001;
        dm_addr = 32'h100;
        push(1'b0, 32'hDEADBEEF);
        last_dm = 32'hDEADBEEF;
        @(negedge clk);
        check("load_stall_pre", {63'd0, stall_mem}, 64'd1);
        check("load_req_pre", {63'd0, mem_req}, 64'd0);
        @(negedge clk);
        check("load_req", {63'd0, mem_req}, 64'd1);
        check("load_we", {63'd0, mem_we}, 64'd0);
        check("load_addr", {32'd0, mem_addr}, 64'h100);
        check("load_be", {60'd0, mem_be}, 64'hF);
        @(negedge clk);
        check("load_valid", {63'd0, dm_valid}, 64'd1);
        check("load_stall_fall", {63'd0, stall_mem}, 64'd0);
        tick();
        dm_read_write = 4'b0000;
        @(negedge clk);
        check("load_pulse_one", {63'd0, dm_valid}, 64'd0);
        check("load_no_regrant", {63'd0, mem_req}, 64'd0);

        // Store with three wait states
        wait_lat = 3;
        tick();
        dm_read_write = 4'b0010;
        dm_addr = 32'h200;
        dm_wdata = 32'h12345678;
        dm_be = 4'b0011;
        push(1'b0, last_dm);
        wait_valid(1'b0, "store_grant_dummy_guard");
        // wait_valid above consumed the completion; verify held cycles via second store
        tick();
        dm_read_write = 4'b0000;
        tick();
        tick();
        tick();
        dm_read_write = 4'b0010;
        dm_addr = 32'h204;
        dm_wdata = 32'hCAFE0001;
        push(1'b0, last_dm);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!mem_req && n < 20) begin
                n++;
                @(negedge clk);
            end
            check("store_req_timeout", {63'd0, n < 20}, 64'd1);
        end
        for (int i = 0; i < 4; i++) begin
            check("store_req", {63'd0, mem_req}, 64'd1);
            check("store_we", {63'd0, mem_we}, 64'd1);
            check("store_be", {60'd0, mem_be}, 64'h3);
            check("store_addr", {32'd0, mem_addr}, 64'h204);
            check("store_wdata", {32'd0, mem_wdata}, 64'hCAFE0001);
            check("store_stall", {63'd0, stall_mem}, 64'd1);
            check("store_no_valid", {63'd0, dm_valid}, 64'd0);
            @(negedge clk);
        end
        check("store_valid", {63'd0, dm_valid}, 64'd1);
        check("store_req_clear", {63'd0, mem_req}, 64'd0);
        tick();
        dm_read_write = 4'b0000;
        @(negedge clk);
        check("store_pulse_one", {63'd0, dm_valid}, 64'd0);

        // Contention: data first, fetch three cycles after dm_valid
        wait_lat = 0;
        tick();
        if_req = 1'b1;
        if_addr = 32'h0;
        dm_read_write = 4'b0001;
        dm_addr = 32'h300;
        push(1'b0, memf(32'h300));
        push(1'b1, memf(32'h0));
        last_dm = memf(32'h300);
        wait_valid(1'b0, "cont_dm");
        t_dm = cyc;
        check("cont_stall_if", {63'd0, stall_if}, 64'd1);
        tick();
        dm_read_write = 4'b0000;
        wait_valid(1'b1, "cont_if");
        t_if = cyc;
        check("cont_gap", 64'(t_if - t_dm), 64'd3);
        check("cont_stall_if_fall", {63'd0, stall_if}, 64'd0);
        tick();
        if_req = 1'b0;

        // Illegal codes produce no request
        foreach (sb[i]) check("sb_drained_before_illegal", 64'd1, 64'd0);
        for (int k = 0; k < 3; k++) begin
            logic [3:0] codes [3];
            codes[0] = 4'b0011;
            codes[1] = 4'b0100;
            codes[2] = 4'b1001;
            tick();
            dm_read_write = codes[k];
            dm_addr = 32'h700;
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                check("illegal_req", {63'd0, mem_req}, 64'd0);
                check("illegal_stall", {63'd0, stall_mem}, 64'd0);
            end
        end
        tick();
        dm_read_write = 4'b0000;

        // Asynchronous reset during an outstanding access
        wait_lat = 1000;
        tick();
        dm_read_write = 4'b0001;
        dm_addr = 32'h400;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_req", {63'd0, mem_req}, 64'd1);
        #2;
        rst_n = 1'b0;
        dm_read_write = 4'b0000;
        #1;
        check_idle_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        wait_lat = 0;
        @(negedge clk);
        check("rst_after_req", {63'd0, mem_req}, 64'd0);
        tick();
        dm_read_write = 4'b0001;
        dm_addr = 32'h100;
        push(1'b0, 32'hDEADBEEF);
        wait_valid(1'b0, "rst_after_load");
        tick();
        dm_read_write = 4'b0000;
        tick();

        // Continuous contention: grant order with and without the starvation guard
        tick();
        if_req = 1'b1;
        if_addr = 32'h40;
        dm_read_write = 4'b0001;
        dm_addr = 32'h500;
`ifdef ARB_STARVE_GUARD_EN
        for (int i = 0; i < 7; i++) push(i == 4, (i == 4) ? memf(32'h40) : memf(32'h500));
`else
        for (int i = 0; i < 7; i++) push(1'b0, memf(32'h500));
`endif
        for (int i = 0; i < 7; i++) wait_any("burst");
        tick();
        if_req = 1'b0;
        dm_read_write = 4'b0000;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between instruction fetch (IF) and the load/store stage (MEM).
- Sequences each access as a request/ready transaction and returns read data to the requester that owns it.
- Generates the IF and MEM stall signals.
- The MEM request is driven directly by the 4-bit read_write control from the main decoder: 0001 = load, 0010 = store, 0000 = none.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
MAX_DATA_BURST, 4, consecutive data grants allowed while a fetch is pending (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request; held with if_addr stable until if_valid
if_addr  in  ADDR_WIDTH  fetch address
if_rdata  out  DATA_WIDTH  fetched instruction, valid with if_valid
if_valid  out  1  one-cycle completion pulse for a fetch
dm_read_write  in  4  decoder memory control (0001 load, 0010 store); held stable until dm_valid
dm_addr  in  ADDR_WIDTH  data address
dm_wdata  in  DATA_WIDTH  store data
dm_be  in  DATA_WIDTH/8  store byte enables
dm_rdata  out  DATA_WIDTH  load data, valid with dm_valid
dm_valid  out  1  one-cycle completion pulse for a load or store
mem_req  out  1  memory request; held until mem_ready
mem_we  out  1  1 = write
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_be  out  DATA_WIDTH/8  memory byte enables; all ones for reads
mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready
mem_ready  in  1  memory completes the current request this cycle
stall_if  out  1  fetch pending, not yet completed
stall_mem  out  1  data access pending, not yet completed

Behaviour:
- Reset values: every output is 0, including all mem_* registers, dm_rdata, if_rdata and the burst counter; state is IDLE.
- Reset is asynchronous. Asserting it mid-transaction drops mem_req immediately and abandons the access; the memory must tolerate this.
- Data request: dm_pend = (dm_read_write == 0001) or (dm_read_write == 0010).
  - Any other value, including 0011 or a nonzero bit 3 or bit 2, is no request.
- FSM states: IDLE, DATA, FETCH.
- IDLE:
  - If dm_pend, go to DATA. Data has priority because it belongs to the older instruction.
  - Else if if_req, go to FETCH.
  - Else stay in IDLE.
  - On the transition, the mem_* outputs are registered: mem_req=1, mem_we = (dm_read_write == 0010), address, wdata, and be (all ones for loads and fetches).
- DATA and FETCH:
  - mem_* outputs are held constant while mem_ready=0; there is no timeout.
  - On mem_ready=1:
    - capture mem_rdata into dm_rdata (loads only; dm_rdata is unchanged on stores) or into if_rdata;
    - pulse the matching valid signal for exactly one cycle;
    - clear mem_req;
    - return to IDLE.
- Latency:
  - Request sampled in IDLE at cycle N; mem_req is high in N+1.
  - If mem_ready is high in N+1, valid is high in N+2.
  - Minimum is 2 cycles per access. The mandatory IDLE turnaround cycle gives at most one access per 3 cycles.
- Stalls (combinational):
  - stall_if = if_req and not if_valid.
  - stall_mem = dm_pend and not dm_valid.
- Simultaneous if_req and dm_pend in IDLE: data wins; the fetch waits in IDLE and is granted after the data access completes.
- Requests are sampled only in IDLE. Requester changes during DATA or FETCH are ignored until the next IDLE.
- mem_ready while in IDLE is ignored.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- With it defined:
  - A counter of width clog2(MAX_DATA_BURST+1) increments on each data grant made while if_req=1.
  - When the counter equals MAX_DATA_BURST and if_req=1, the next IDLE arbitration grants FETCH even if dm_pend.
  - The counter clears on any fetch grant and whenever if_req=0 in IDLE.
- Without it: strict data priority; no counter logic.

Test Plan:
- Single load: dm_read_write=0001, dm_addr=0x100, mem_ready tied 1, mem_rdata=0xDEADBEEF -> mem_req high with mem_we=0, mem_addr=0x100; dm_valid pulses 1 cycle later with dm_rdata=0xDEADBEEF; stall_mem falls in the same cycle.
- Store with wait states: dm_read_write=0010, dm_addr=0x200, dm_wdata=0x12345678, dm_be=0011, mem_ready low 3 cycles -> mem_we=1, mem_be=0011, mem_addr/mem_wdata stable for 4 cycles; one dm_valid pulse; dm_rdata unchanged.
- Contention: if_req=1 (if_addr=0x0) and load pending in the same cycle -> data granted first; fetch granted after IDLE; if_valid follows dm_valid by 3 cycles with mem_ready=1.
- Illegal code: dm_read_write=0011 and 0100 with if_req=0 -> mem_req stays 0; stall_mem=0.
- Reset mid-access: rst_n low while in DATA with mem_ready=0 -> mem_req and all outputs 0 asynchronously; state IDLE after release.
- With ARB_STARVE_GUARD_EN, MAX_DATA_BURST=4: dm_pend and if_req continuously high -> grant order D,D,D,D,F,D,... Without the macro, F is never granted.
